// File: rtl/loop_decrement.sv
// loop_decrement: hardware loop counter for the custom RISC core.
//
// Decode pushes {iteration count, loop-start address} entries onto a small
// LIFO so loops can nest. Each loop_end strobe works on the innermost (top)
// entry. If the count is above one, the count is decremented and a
// registered branch-back to the start address is issued. If the count is
// one, the entry is popped and a registered done pulse is issued.
//
// Configuration macros:
//   DATASIZE        - default DATAWIDTH (falls back to 16 when not defined)
//   LOOP_ERR_CLR_EN - adds the err_clr input, which clears the sticky error flags
//
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   load           - push request; count_in/addr_in give the new loop
//   loop_end       - last instruction of the current loop body retired
//   err_clr        - (LOOP_ERR_CLR_EN only) clears the sticky error flags
//   taken          - registered; branch back to target_addr this cycle
//   target_addr    - registered; branch target, valid when taken=1
//   done           - registered; innermost loop completed last edge
//   zero_skip      - registered; load with count_in==0 seen last edge
//   active         - stack non-empty
//   level          - stack occupancy, 0..DEPTH
//   overflow_err   - sticky; load rejected because the stack was full
//   underflow_err  - sticky; loop_end received while the stack was empty

`ifndef DATASIZE
`define DATASIZE 16
`endif

module loop_decrement #(
    parameter int DATAWIDTH = `DATASIZE,
    parameter int DEPTH     = 4,
    parameter int PTRW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] count_in,
    input  logic [DATAWIDTH-1:0] addr_in,
    input  logic                 loop_end,
`ifdef LOOP_ERR_CLR_EN
    input  logic                 err_clr,
`endif
    output logic                 taken,
    output logic [DATAWIDTH-1:0] target_addr,
    output logic                 done,
    output logic                 zero_skip,
    output logic                 active,
    output logic [PTRW:0]        level,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam logic [PTRW:0]        LVL_FULL = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]        LVL_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0]      IDX_ONE  = PTRW'(1);
    localparam logic [DATAWIDTH-1:0] CNT_ONE  = DATAWIDTH'(1);

    logic [DATAWIDTH-1:0] cnt_q  [DEPTH];
    logic [DATAWIDTH-1:0] cnt_d  [DEPTH];
    logic [DATAWIDTH-1:0] addr_q [DEPTH];
    logic [DATAWIDTH-1:0] addr_d [DEPTH];

    logic [PTRW:0]        level_q, level_d;
    logic                 taken_q, taken_d;
    logic [DATAWIDTH-1:0] target_addr_q, target_addr_d;
    logic                 done_q, done_d;
    logic                 zero_skip_q, zero_skip_d;
    logic                 overflow_err_q, overflow_err_d;
    logic                 underflow_err_q, underflow_err_d;

    logic [PTRW-1:0]      top_idx;
    logic [DATAWIDTH-1:0] top_cnt;
    logic                 le_valid;
    logic                 do_pop;
    logic                 do_dec;
    logic [PTRW:0]        level_mid;
    logic                 count_nz;
    logic                 do_push;
    logic                 ovf_event;
    logic                 unf_event;
    logic                 clr_req;

`ifdef LOOP_ERR_CLR_EN
    assign clr_req = err_clr;
`else
    assign clr_req = 1'b0;
`endif

    always_comb begin
        // When level==DEPTH the low PTRW bits wrap to 0, so minus one still
        // lands on the last slot.
        top_idx   = level_q[PTRW-1:0] - IDX_ONE;
        top_cnt   = cnt_q[top_idx];
        le_valid  = loop_end && (level_q != '0);
        // Counts of zero are never pushed; <= keeps a stray zero from
        // wrapping into a huge loop.
        do_pop    = le_valid && (top_cnt <= CNT_ONE);
        do_dec    = le_valid && !do_pop;
        unf_event = loop_end && (level_q == '0);

        // The loop_end is applied first; the load sees the post-pop stack.
        level_mid = do_pop ? (level_q - LVL_ONE) : level_q;
        count_nz  = (count_in != '0);
        do_push   = load && count_nz && (level_mid != LVL_FULL);
        ovf_event = load && count_nz && (level_mid == LVL_FULL);

        level_d   = do_push ? (level_mid + LVL_ONE) : level_mid;

        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (do_dec) begin
            cnt_d[top_idx] = top_cnt - CNT_ONE;
        end
        // A decrement touches slot level-1 and a push touches slot level_mid,
        // so they never collide unless a pop freed the top slot.
        if (do_push) begin
            cnt_d[level_mid[PTRW-1:0]]  = count_in;
            addr_d[level_mid[PTRW-1:0]] = addr_in;
        end

        taken_d         = do_dec;
        target_addr_d   = do_dec ? addr_q[top_idx] : target_addr_q;
        done_d          = do_pop;
        zero_skip_d     = load && !count_nz;
        // A new error event wins over a clear in the same cycle.
        overflow_err_d  = ovf_event || (overflow_err_q && !clr_req);
        underflow_err_d = unf_event || (underflow_err_q && !clr_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q         <= '0;
            taken_q         <= 1'b0;
            target_addr_q   <= '0;
            done_q          <= 1'b0;
            zero_skip_q     <= 1'b0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            level_q         <= level_d;
            taken_q         <= taken_d;
            target_addr_q   <= target_addr_d;
            done_q          <= done_d;
            zero_skip_q     <= zero_skip_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Stack contents are don't-care after reset; level_q alone marks validity.
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        addr_q <= addr_d;
    end

    assign taken         = taken_q;
    assign target_addr   = target_addr_q;
    assign done          = done_q;
    assign zero_skip     = zero_skip_q;
    assign active        = (level_q != '0);
    assign level         = level_q;
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_loop_decrement.sv
// Directed bench for loop_decrement with hand-computed expectations.
module tb_loop_decrement;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] count_in = '0;
    logic [DW-1:0] addr_in = '0;
    logic          loop_end = 1'b0;
`ifdef LOOP_ERR_CLR_EN
    logic          err_clr = 1'b0;
`endif
    logic          taken;
    logic [DW-1:0] target_addr;
    logic          done;
    logic          zero_skip;
    logic          active;
    logic [2:0]    level;
    logic          overflow_err;
    logic          underflow_err;

    int n_checks = 0;
    int n_errors = 0;

    loop_decrement #(.DATAWIDTH(DW), .DEPTH(4), .PTRW(2)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .count_in(count_in),
        .addr_in(addr_in),
        .loop_end(loop_end),
`ifdef LOOP_ERR_CLR_EN
        .err_clr(err_clr),
`endif
        .taken(taken),
        .target_addr(target_addr),
        .done(done),
        .zero_skip(zero_skip),
        .active(active),
        .level(level),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the edge.
    task automatic cyc(input logic ld, input logic [DW-1:0] c, input logic [DW-1:0] a,
                       input logic le, input logic r);
        load = ld; count_in = c; addr_in = a; loop_end = le; rst = r;
        @(posedge clk);
        #1;
        load = 1'b0; loop_end = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_taken", taken, 0);
        check("rst_tgt", target_addr, 0);
        check("rst_done", done, 0);
        check("rst_zs", zero_skip, 0);
        check("rst_level", level, 0);
        check("rst_active", active, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_unf", underflow_err, 0);

        // Basic loop: count 3 at 0x0040
        cyc(1'b1, 16'd3, 16'h0040, 1'b0, 1'b0);
        check("b_load_level", level, 1);
        check("b_load_active", active, 1);
        check("b_load_taken", taken, 0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b_le1_taken", taken, 1);
        check("b_le1_tgt", target_addr, 16'h0040);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b_le2_taken", taken, 1);
        check("b_le2_tgt", target_addr, 16'h0040);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("b_le3_done", done, 1);
        check("b_le3_taken", taken, 0);
        check("b_le3_level", level, 0);
        check("b_le3_active", active, 0);
        check("b_le3_tgt_hold", target_addr, 16'h0040);
        idle();
        check("b_done_pulse", done, 0);

        // Nesting
        cyc(1'b1, 16'd2, 16'h0010, 1'b0, 1'b0);
        cyc(1'b1, 16'd2, 16'h0020, 1'b0, 1'b0);
        check("n_level0", level, 2);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("n1_taken", taken, 1);
        check("n1_tgt", target_addr, 16'h0020);
        check("n1_level", level, 2);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("n2_done", done, 1);
        check("n2_taken", taken, 0);
        check("n2_level", level, 1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("n3_taken", taken, 1);
        check("n3_tgt", target_addr, 16'h0010);
        check("n3_level", level, 1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("n4_done", done, 1);
        check("n4_level", level, 0);

        // Underflow
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("u_unf", underflow_err, 1);
        check("u_level", level, 0);
        check("u_taken", taken, 0);
        check("u_done", done, 0);
        idle();
        check("u_sticky", underflow_err, 1);

        // Zero count
        cyc(1'b1, 16'd0, 16'h0050, 1'b0, 1'b0);
        check("z_zs", zero_skip, 1);
        check("z_level", level, 0);
        idle();
        check("z_pulse", zero_skip, 0);

        // Overflow: five loads of count 5
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'd5, 16'h0100 + 16'(i * 4), 1'b0, 1'b0);
        end
        check("o_level", level, 4);
        check("o_ovf", overflow_err, 1);
        check("o_taken", taken, 0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("o_le_taken", taken, 1);
        check("o_le_tgt", target_addr, 16'h010C);

        // Simultaneous pop + load at full
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("s_rst_ovf", overflow_err, 0);
        check("s_rst_unf", underflow_err, 0);
        cyc(1'b1, 16'd5, 16'h0200, 1'b0, 1'b0);
        cyc(1'b1, 16'd5, 16'h0204, 1'b0, 1'b0);
        cyc(1'b1, 16'd5, 16'h0208, 1'b0, 1'b0);
        cyc(1'b1, 16'd1, 16'h020C, 1'b0, 1'b0);
        check("s_level_full", level, 4);
        cyc(1'b1, 16'd7, 16'h0080, 1'b1, 1'b0);
        check("s_done", done, 1);
        check("s_level", level, 4);
        check("s_ovf", overflow_err, 0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("s_top_taken", taken, 1);
        check("s_top_tgt", target_addr, 16'h0080);

        // All-ones count and decrement alongside a push
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b1, 16'hFFFF, 16'h0400, 1'b0, 1'b0);
        cyc(1'b1, 16'd2, 16'h0500, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("w_dec_taken", taken, 1);
        check("w_dec_tgt", target_addr, 16'h0500);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("w_pop_done", done, 1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("w_ones_taken", taken, 1);
        check("w_ones_tgt", target_addr, 16'h0400);
        check("w_ones_level", level, 1);

        // Reset mid-loop
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        cyc(1'b1, 16'd10, 16'h0300, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("r_pre_taken", taken, 1);
        check("r_pre_tgt", target_addr, 16'h0300);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("r_taken", taken, 0);
        check("r_tgt", target_addr, 0);
        check("r_done", done, 0);
        check("r_level", level, 0);
        check("r_active", active, 0);
        check("r_unf0", underflow_err, 0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("r_unf", underflow_err, 1);
        check("r_taken2", taken, 0);
`ifdef LOOP_ERR_CLR_EN
        err_clr = 1'b1;
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        err_clr = 1'b0;
        check("c_event_wins", underflow_err, 1);
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        check("c_clr_unf", underflow_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
